apb_mr_rank_responder: RTL

Backend responder for the APB slave port's mode-register rank interface. It consumes the per-rank MRW/MRR request levels that the slave port drives on `rank_mrw_o` / `rank_mrr_o`, and serialises them into one command at a time toward the DRAM command path. After a programmable latency it returns a one-cycle per-rank done pulse into the slave's `mrw_done_status_i` / `mrr_done_status_i`. It replaces the behavioural done-status model used in simulation and sits between the APB slave port and the PHY command interface.

---
 rtl/apb_mr_rank_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/apb_mr_rank_responder.sv
// Serialises per-rank MRW/MRR request edges into one PHY command at a time and
// returns a one-cycle per-rank done pulse MR_LATENCY cycles after acceptance.
module apb_mr_rank_responder #(
    parameter int NB_RANK    = 8,
    parameter int MR_LATENCY = 3,
    parameter int RANK_W     = (NB_RANK > 1) ? $clog2(NB_RANK) : 1
) (
    input  logic               pclk_i,
    input  logic               prst_ni,
    input  logic [NB_RANK-1:0] rank_mrw_i,
    input  logic [NB_RANK-1:0] rank_mrr_i,
    output logic [NB_RANK-1:0] mrw_done_status_o,
    output logic [NB_RANK-1:0] mrr_done_status_o,
    output logic               cmd_valid_o,
    input  logic               cmd_ready_i,
    output logic [RANK_W-1:0]  cmd_rank_o,
    output logic               cmd_is_read_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state;
    logic [NB_RANK-1:0] mrw_q, mrr_q;
    logic [NB_RANK-1:0] pend_mrw, pend_mrr;
    logic [NB_RANK-1:0] rise_mrw, rise_mrr;
    logic [NB_RANK-1:0] clr_mrw, clr_mrr;
    logic [NB_RANK-1:0] sel;
    logic [RANK_W-1:0]  rr_ptr, pick_rank, next_ptr;
    logic               pick_rd, found;
    logic [7:0]         cnt;
    int                 idx;

    always_comb begin
        rise_mrw = rank_mrw_i & ~mrw_q;
        rise_mrr = rank_mrr_i & ~mrr_q;
        clr_mrw  = '0;
        clr_mrr  = '0;
        if (state == DONE) begin
            if (cmd_is_read_o) clr_mrr[cmd_rank_o] = 1'b1;
            else               clr_mrw[cmd_rank_o] = 1'b1;
        end
    end

    // Writes always beat reads; within a type, search upward from rr_ptr with wrap.
    always_comb begin
        pick_rd   = ~(|pend_mrw);
        sel       = pick_rd ? pend_mrr : pend_mrw;
        pick_rank = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NB_RANK; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NB_RANK) idx = idx - NB_RANK;
            if (!found && sel[idx]) begin
                found     = 1'b1;
                pick_rank = RANK_W'(idx);
            end
        end
        next_ptr = (cmd_rank_o == RANK_W'(NB_RANK - 1)) ? '0 : cmd_rank_o + RANK_W'(1);
    end

    assign busy_o = (state != IDLE) || (|pend_mrw) || (|pend_mrr);

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            state             <= IDLE;
            mrw_q             <= '0;
            mrr_q             <= '0;
            pend_mrw          <= '0;
            pend_mrr          <= '0;
            rr_ptr            <= '0;
            cnt               <= '0;
            mrw_done_status_o <= '0;
            mrr_done_status_o <= '0;
            cmd_valid_o       <= 1'b0;
            cmd_rank_o        <= '0;
            cmd_is_read_o     <= 1'b0;
        end else begin
            mrw_q             <= rank_mrw_i;
            mrr_q             <= rank_mrr_i;
            // A fresh edge in the DONE cycle outranks the clear.
            pend_mrw          <= (pend_mrw & ~clr_mrw) | rise_mrw;
            pend_mrr          <= (pend_mrr & ~clr_mrr) | rise_mrr;
            mrw_done_status_o <= '0;
            mrr_done_status_o <= '0;
            case (state)
                IDLE: begin
                    if ((|pend_mrw) || (|pend_mrr)) begin
                        state         <= ISSUE;
                        cmd_valid_o   <= 1'b1;
                        cmd_rank_o    <= pick_rank;
                        cmd_is_read_o <= pick_rd;
                    end
                end
                ISSUE: begin
                    if (cmd_ready_i) begin
                        state       <= WAIT;
                        cmd_valid_o <= 1'b0;
                        cnt         <= 8'(MR_LATENCY);
                        rr_ptr      <= next_ptr;
                    end
                end
                WAIT: begin
                    if (cnt == 8'd1) begin
                        state <= DONE;
                        cnt   <= '0;
                        if (cmd_is_read_o) mrr_done_status_o[cmd_rank_o] <= 1'b1;
                        else               mrw_done_status_o[cmd_rank_o] <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
